// File: rtl/pipeline_stage_register.sv
// ============================================================================
// Module   : pipeline_stage_register
// Purpose  : Parametrised inter-stage pipeline register carrying PC, data and
//            control with valid/ready flow control, flush and an optional skid.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipeline_stage_register #(
    parameter int                    PC_WIDTH   = 32,
    parameter int                    DATA_WIDTH = 101,
    parameter int                    CTRL_WIDTH = 10,
    parameter logic [CTRL_WIDTH-1:0] CTRL_NOP   = 10'h001,
    parameter int                    SKID       = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [PC_WIDTH-1:0]   in_pc,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [CTRL_WIDTH-1:0] in_ctrl,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [PC_WIDTH-1:0]   out_pc,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [CTRL_WIDTH-1:0] out_ctrl
);

    localparam logic [1:0] ST_EMPTY   = 2'd0;
    localparam logic [1:0] ST_FULL    = 2'd1;
    localparam logic [1:0] ST_SKIDDED = 2'd2;

    logic [1:0]            state_q,     state_d;
    logic [PC_WIDTH-1:0]   head_pc_q,   head_pc_d;
    logic [DATA_WIDTH-1:0] head_data_q, head_data_d;
    logic [CTRL_WIDTH-1:0] head_ctrl_q, head_ctrl_d;
    logic [PC_WIDTH-1:0]   skid_pc_q,   skid_pc_d;
    logic [DATA_WIDTH-1:0] skid_data_q, skid_data_d;
    logic [CTRL_WIDTH-1:0] skid_ctrl_q, skid_ctrl_d;
    logic                  accept_w;
    logic                  take_w;

    assign out_valid = (state_q != ST_EMPTY);
    assign accept_w  = in_valid & in_ready;
    assign take_w    = out_valid & out_ready;
    assign out_pc    = head_pc_q;
    assign out_data  = head_data_q;
    // Bubbles present a NOP so downstream never has to gate control on valid.
    assign out_ctrl  = out_valid ? head_ctrl_q : CTRL_NOP;

    always_comb begin
        state_d     = state_q;
        head_pc_d   = head_pc_q;
        head_data_d = head_data_q;
        head_ctrl_d = head_ctrl_q;
        skid_pc_d   = skid_pc_q;
        skid_data_d = skid_data_q;
        skid_ctrl_d = skid_ctrl_q;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept_w) begin
                        state_d     = ST_FULL;
                        head_pc_d   = in_pc;
                        head_data_d = in_data;
                        head_ctrl_d = in_ctrl;
                    end
                end
                ST_FULL: begin
                    if (accept_w && (take_w || SKID == 0)) begin
                        head_pc_d   = in_pc;
                        head_data_d = in_data;
                        head_ctrl_d = in_ctrl;
                    end else if (accept_w) begin
                        state_d     = ST_SKIDDED;
                        skid_pc_d   = in_pc;
                        skid_data_d = in_data;
                        skid_ctrl_d = in_ctrl;
                    end else if (take_w) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_SKIDDED: begin
                    if (take_w) begin
                        state_d     = ST_FULL;
                        head_pc_d   = skid_pc_q;
                        head_data_d = skid_data_q;
                        head_ctrl_d = skid_ctrl_q;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_EMPTY;
            head_pc_q   <= '0;
            head_data_q <= '0;
            head_ctrl_q <= CTRL_NOP;
            skid_pc_q   <= '0;
            skid_data_q <= '0;
            skid_ctrl_q <= CTRL_NOP;
        end else begin
            state_q     <= state_d;
            head_pc_q   <= head_pc_d;
            head_data_q <= head_data_d;
            head_ctrl_q <= head_ctrl_d;
            skid_pc_q   <= skid_pc_d;
            skid_data_q <= skid_data_d;
            skid_ctrl_q <= skid_ctrl_d;
        end
    end

    generate
        if (SKID != 0) begin : g_skid_ready
            logic in_ready_q;
            // Registered ready: the skid slot absorbs the one entry in flight.
            always_ff @(posedge clk) begin
                if (rst) begin
                    in_ready_q <= 1'b1;
                end else begin
                    in_ready_q <= (state_d != ST_SKIDDED);
                end
            end
            assign in_ready = in_ready_q;
        end else begin : g_comb_ready
            assign in_ready = ~out_valid | out_ready;
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_pipeline_stage_register.sv
// ============================================================================
// Module   : tb_pipeline_stage_register
// Purpose  : Directed scoreboard bench driving a SKID=1 and a SKID=0 instance.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipeline_stage_register;

    localparam logic [9:0] NOP = 10'h001;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         flush = 1'b0;
    logic         in_valid = 1'b0;
    logic [31:0]  in_pc = '0;
    logic [100:0] in_data;
    logic [9:0]   in_ctrl;
    logic         out_ready = 1'b0;

    logic         s_in_ready, s_out_valid;
    logic [31:0]  s_out_pc;
    logic [100:0] s_out_data;
    logic [9:0]   s_out_ctrl;
    logic         c_in_ready, c_out_valid;
    logic [31:0]  c_out_pc;
    logic [100:0] c_out_data;
    logic [9:0]   c_out_ctrl;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] q_s[$];
    logic [31:0] q_c[$];

    function automatic logic [100:0] data_of(logic [31:0] pc);
        return {5'h15, pc, ~pc, pc ^ 32'h5a5a_5a5a};
    endfunction

    function automatic logic [9:0] ctrl_of(logic [31:0] pc);
        return {pc[9:2], 2'b10};
    endfunction

    assign in_data = data_of(in_pc);
    assign in_ctrl = ctrl_of(in_pc);

    always #5 clk = ~clk;

    pipeline_stage_register #(.SKID(1)) dut_skid (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(s_in_ready),
        .in_pc(in_pc), .in_data(in_data), .in_ctrl(in_ctrl),
        .out_valid(s_out_valid), .out_ready(out_ready),
        .out_pc(s_out_pc), .out_data(s_out_data), .out_ctrl(s_out_ctrl)
    );

    pipeline_stage_register #(.SKID(0)) dut_comb (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(c_in_ready),
        .in_pc(in_pc), .in_data(in_data), .in_ctrl(in_ctrl),
        .out_valid(c_out_valid), .out_ready(out_ready),
        .out_pc(c_out_pc), .out_data(c_out_data), .out_ctrl(c_out_ctrl)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_unit(input string nm, input logic rdy, input logic vld,
                              input logic [31:0] pc, input logic [100:0] dat,
                              input logic [9:0] ctl, input logic [31:0] q[$],
                              input logic exp_rdy);
        chk({nm, ".in_ready"}, 128'(rdy), 128'(exp_rdy));
        chk({nm, ".out_valid"}, 128'(vld), 128'(q.size() != 0));
        if (q.size() != 0) begin
            chk({nm, ".out_pc"}, 128'(pc), 128'(q[0]));
            chk({nm, ".out_data"}, 128'(dat), 128'(data_of(q[0])));
            chk({nm, ".out_ctrl"}, 128'(ctl), 128'(ctrl_of(q[0])));
        end else begin
            chk({nm, ".out_ctrl_nop"}, 128'(ctl), 128'(NOP));
        end
    endtask

    // One cycle: drive inputs, check pre-edge outputs against the models,
    // then advance the models by the transfer that the edge will perform.
    task automatic cyc(input logic v, input logic [31:0] pc, input logic ordy, input logic fl);
        logic s_rdy, c_rdy, s_acc, c_acc, s_tak, c_tak;
        in_valid  = v;
        in_pc     = pc;
        out_ready = ordy;
        flush     = fl;
        #1;
        s_rdy = (q_s.size() != 2);
        c_rdy = (q_c.size() == 0) || ordy;
        check_unit("skid", s_in_ready, s_out_valid, s_out_pc, s_out_data, s_out_ctrl, q_s, s_rdy);
        check_unit("comb", c_in_ready, c_out_valid, c_out_pc, c_out_data, c_out_ctrl, q_c, c_rdy);
        s_acc = v && s_rdy;
        c_acc = v && c_rdy;
        s_tak = (q_s.size() != 0) && ordy;
        c_tak = (q_c.size() != 0) && ordy;
        if (s_tak) void'(q_s.pop_front());
        if (c_tak) void'(q_c.pop_front());
        if (fl) begin
            q_s.delete();
            q_c.delete();
        end else begin
            if (s_acc) q_s.push_back(pc);
            if (c_acc) q_c.push_back(pc);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset(input logic v);
        rst      = 1'b1;
        in_valid = v;
        @(posedge clk);
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        q_s.delete();
        q_c.delete();
        #1;
        chk("skid.rst_pc", 128'(s_out_pc), 128'(0));
        chk("skid.rst_data", 128'(s_out_data), 128'(0));
        chk("comb.rst_pc", 128'(c_out_pc), 128'(0));
        chk("comb.rst_data", 128'(c_out_data), 128'(0));
    endtask

    task automatic drain(input string nm);
        for (int i = 0; i < 4; i++) cyc(1'b0, 32'h0, 1'b1, 1'b0);
        chk({nm, ".skid_empty"}, 128'(q_s.size()), 128'(0));
        chk({nm, ".comb_empty"}, 128'(q_c.size()), 128'(0));
    endtask

    initial begin
        @(negedge clk);
        do_reset(1'b0);

        // Streaming with the consumer always ready
        cyc(1'b1, 32'h0, 1'b1, 1'b0);
        cyc(1'b1, 32'h4, 1'b1, 1'b0);
        cyc(1'b1, 32'h8, 1'b1, 1'b0);
        cyc(1'b1, 32'hC, 1'b1, 1'b0);
        drain("stream");

        // Stall: fill head and skid, hold 0x28 upstream, then release
        cyc(1'b1, 32'h20, 1'b0, 1'b0);
        cyc(1'b1, 32'h24, 1'b0, 1'b0);
        cyc(1'b1, 32'h28, 1'b0, 1'b0);
        cyc(1'b1, 32'h28, 1'b0, 1'b0);
        cyc(1'b1, 32'h28, 1'b1, 1'b0);
        cyc(1'b1, 32'h28, 1'b1, 1'b0);
        drain("stall");

        // Flush while SKIDDED with a new entry presented
        cyc(1'b1, 32'h40, 1'b0, 1'b0);
        cyc(1'b1, 32'h44, 1'b0, 1'b0);
        cyc(1'b1, 32'h30, 1'b0, 1'b1);
        cyc(1'b0, 32'h0, 1'b0, 1'b0);
        drain("flush");

        // Flush with a same-cycle take
        cyc(1'b1, 32'h48, 1'b0, 1'b0);
        cyc(1'b1, 32'h4C, 1'b1, 1'b1);
        drain("flush_take");

        // Consumer toggling ready
        for (int i = 0; i < 6; i++)
            cyc(1'b1, 32'h50 + 32'(4 * i), 1'(i % 2 == 0), 1'b0);
        drain("toggle");

        // Simultaneous accept and take, then hold under back-pressure
        cyc(1'b1, 32'h60, 1'b0, 1'b0);
        cyc(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0);
        cyc(1'b0, 32'h0, 1'b0, 1'b0);
        cyc(1'b0, 32'h0, 1'b0, 1'b0);
        drain("acc_take");

        // Reset in the middle of a SKIDDED hold
        cyc(1'b1, 32'h10, 1'b0, 1'b0);
        cyc(1'b1, 32'h14, 1'b0, 1'b0);
        out_ready = 1'b0;
        do_reset(1'b1);
        cyc(1'b0, 32'h0, 1'b0, 1'b0);
        drain("reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
